nibble_cpu_core: RTL and testbench
==================================

# nibble_cpu_core

Parametrised successor to the three-phase nibble CPU: fetches each instruction as three DW-bit words from a shared program/data bus, executes register/immediate ALU, load/store and conditional-jump instructions, and talks to memory through a req/ready handshake so slow external memories can insert wait states. Sits between the top-level pin mux, which maps the mem_* bus onto the IO pins, and off-chip memory.

## Interface
- DW, 4: data/register width; legal 4..16
- AW, 10: word address width; legal >= 4
- NREG, 4: general registers; power of 2, 2..8, log2(NREG) <= DW
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- mem_req  out  1  bus transaction request
- mem_we  out  1  1 = write (store), 0 = read
- mem_data_sel  out  1  0 = program fetch, 1 = data access
- mem_addr  out  AW  word address
- mem_wdata  out  DW  store data
- mem_rdata  in  DW  read data, valid when mem_ready = 1
- mem_ready  in  1  completes the current transaction
- flag_z, flag_c  out  1  zero / carry flags
- halted  out  1  core stopped

## Operation
- States: F1, F2, F3, MEM, HALT. Transactions complete at an edge where mem_req && mem_ready; otherwise the state and all outputs hold (wait state).
- pc is AW-2 bits (instruction index). Fetch address = {pc, phase}, phase = 0/1/2 in F1/F2/F3; low-bit value 3 is never issued.
- F1 captures w1, F2 captures w2, F3 completes the fetch with w3 = operand, taken directly from mem_rdata.
- Fields: op = w1[3:0]; rd = w2[log2(NREG)-1:0]; operand = w3; upper bits ignored.
- Ops executed at F3 completion (then pc+1, unless stated, -> F1):
  - 0 NOP
  - 1 LDI: rd = operand
  - 4 ADD: {C, rd} = rd + operand
  - 6 AND: rd &= operand
  - 7 XOR: rd ^= operand
  - 8 JMP: pc = operand, zero-extended/truncated to AW-2
  - 9 JZ: jump if Z, else pc+1
  - 10 JC: jump if C, else pc+1
  - 11 HALT -> HALT; pc unchanged
  - 12-15 NOP
- Ops continuing to MEM (mem_data_sel = 1, mem_addr = operand zero-extended to AW; write back and pc+1 at MEM completion, then -> F1):
  - 2 LD: rd = mem_rdata
  - 3 ST: mem_we = 1, mem_wdata = rd
  - 5 ADDM: {C, rd} = rd + mem_rdata
- Flags: Z = (result == 0) on every register write; C written only by ADD/ADDM (carry out of DW bits, result wraps mod 2^DW); all other ops leave flags untouched.
- HALT: mem_req = 0, halted = 1 until rst.
- pc wraps from 2^(AW-2)-1 to 0.
- Reset (any state, including mid-transaction or wait state): state F1, pc = 0, registers = 0, w1/w2 = 0, Z = C = 0, halted = 0. A store pending at a reset edge is not committed; memory sees mem_req only.

## Timing
- mem_req = 1 in F1/F2/F3/MEM, 0 in HALT; all mem_* outputs are registered-state decodes, no combinational path from mem_rdata/mem_ready to outputs.
- First cycle after reset: mem_req = 1, mem_addr = 0, mem_we = 0, mem_data_sel = 0.
- Zero wait states: immediate/jump ops take 3 cycles; LD/ST/ADDM take 4 cycles.
- Each cycle mem_ready is low adds exactly one cycle.
- A register written at F3/MEM completion is visible to the next instruction's operands.
- Flags are visible on flag_z/flag_c the cycle after that completion.

## Test plan
- Reset then LDI r1,5; ADD r1,0xC with ready tied high -> r1 = 1, C = 1, Z = 0; ADD completes 6 cycles after reset release.
- ST r1 to 0x7, then LD r2 from 0x7 -> write at addr 0x007 with mem_data_sel = 1, wdata = 1; r2 = 1; each op takes 4 cycles.
- XOR r0,0 on r0 = 0, then JZ 0xA -> next fetch address = 0x028; JC with C = 0 falls through to pc+1.
- mem_ready low for 3 cycles during F2 -> mem_addr and state hold; instruction completes 3 cycles late with an identical result.
- Execute at pc = 0xFF, AW = 10 -> next fetch address = 0x000; HALT -> mem_req = 0, halted = 1; rst asserted during MEM of a ST -> no write committed, fetch restarts at address 0.

Source files
------------

// File: rtl/nibble_cpu_core_if.sv
// Shared program/data memory bus of the nibble CPU core.
// The core drives the request side; memory answers with read data and ready.
interface nibble_cpu_core_if #(
    parameter int DW = 4,
    parameter int AW = 10
);
    logic          mem_req;
    logic          mem_we;
    logic          mem_data_sel;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_data_sel, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_data_sel, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/nibble_cpu_core.sv
// Nibble CPU core: three-word instruction fetch, ALU/load/store/branch execute,
// req/ready memory handshake with wait states. All bus outputs are registered.
module nibble_cpu_core #(
    parameter int DW   = 4,
    parameter int AW   = 10,
    parameter int NREG = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    nibble_cpu_core_if.master bus,
    output logic              o_flag_z,
    output logic              o_flag_c,
    output logic              o_halted
);
    localparam int PW = AW - 2;
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [PW-1:0] PC_ONE = {{(PW-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_ADDM = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_JC   = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd11;

    typedef enum logic [2:0] {
        S_F1   = 3'd0,
        S_F2   = 3'd1,
        S_F3   = 3'd2,
        S_MEM  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pc;
    logic [DW-1:0] r_w1;
    logic [DW-1:0] r_w2;
    logic [DW-1:0] r_regs [NREG];
    logic          r_req;
    logic          r_we;
    logic          r_sel;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_z;
    logic          r_c;
    logic          r_halted;

    logic          w_done;
    logic [3:0]    w_op;
    logic [RW-1:0] w_rd;
    logic [DW-1:0] w_src;
    logic [DW:0]   w_sum;
    logic [PW-1:0] w_pc_inc;
    logic [PW-1:0] w_jmp_pc;
    logic [PW-1:0] w_next_pc;
    logic          w_wr_en;
    logic          w_wr_c;
    logic [DW-1:0] w_res;
    logic          w_unused_bits;

    // Upper bits of the opcode and register-select words are don't-care.
    assign w_unused_bits = ^{r_w1, r_w2};

    assign w_done   = r_req && bus.mem_ready;
    assign w_op     = r_w1[3:0];
    assign w_rd     = r_w2[RW-1:0];
    assign w_src    = r_regs[w_rd];
    assign w_sum    = {1'b0, w_src} + {1'b0, bus.mem_rdata};
    assign w_pc_inc = r_pc + PC_ONE;
    assign w_jmp_pc = PW'(bus.mem_rdata);

    // Register write-back value/enable and the next pc for F3/MEM completion.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_c    = 1'b0;
        w_res     = w_src;
        w_next_pc = w_pc_inc;
        if (r_state == S_F3) begin
            case (w_op)
                OP_LDI:  begin w_wr_en = 1'b1; w_res = bus.mem_rdata; end
                OP_ADD:  begin w_wr_en = 1'b1; w_wr_c = 1'b1; w_res = w_sum[DW-1:0]; end
                OP_AND:  begin w_wr_en = 1'b1; w_res = w_src & bus.mem_rdata; end
                OP_XOR:  begin w_wr_en = 1'b1; w_res = w_src ^ bus.mem_rdata; end
                OP_JMP:  w_next_pc = w_jmp_pc;
                OP_JZ:   w_next_pc = r_z ? w_jmp_pc : w_pc_inc;
                OP_JC:   w_next_pc = r_c ? w_jmp_pc : w_pc_inc;
                default: w_next_pc = w_pc_inc;
            endcase
        end else if (r_state == S_MEM) begin
            case (w_op)
                OP_LD:   begin w_wr_en = 1'b1; w_res = bus.mem_rdata; end
                OP_ADDM: begin w_wr_en = 1'b1; w_wr_c = 1'b1; w_res = w_sum[DW-1:0]; end
                default: w_wr_en = 1'b0;
            endcase
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Sequencer, register file, flags and registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_F1;
            r_pc     <= {PW{1'b0}};
            r_w1     <= {DW{1'b0}};
            r_w2     <= {DW{1'b0}};
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {DW{1'b0}};
            end
            r_req    <= 1'b1;
            r_we     <= 1'b0;
            r_sel    <= 1'b0;
            r_addr   <= {AW{1'b0}};
            r_wdata  <= {DW{1'b0}};
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_done) begin
            if (w_wr_en) begin
                r_regs[w_rd] <= w_res;
                r_z          <= (w_res == {DW{1'b0}});
            end
            if (w_wr_c) begin
                r_c <= w_sum[DW];
            end
            case (r_state)
                S_F1: begin
                    r_w1    <= bus.mem_rdata;
                    r_addr  <= {r_pc, 2'd1};
                    r_state <= S_F2;
                end
                S_F2: begin
                    r_w2    <= bus.mem_rdata;
                    r_addr  <= {r_pc, 2'd2};
                    r_state <= S_F3;
                end
                S_F3: begin
                    case (w_op)
                        OP_LD, OP_ST, OP_ADDM: begin
                            r_addr  <= AW'(bus.mem_rdata);
                            r_sel   <= 1'b1;
                            r_we    <= (w_op == OP_ST);
                            r_wdata <= w_src;
                            r_state <= S_MEM;
                        end
                        OP_HALT: begin
                            r_req    <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            r_pc    <= w_next_pc;
                            r_addr  <= {w_next_pc, 2'd0};
                            r_state <= S_F1;
                        end
                    endcase
                end
                S_MEM: begin
                    r_pc    <= w_pc_inc;
                    r_addr  <= {w_pc_inc, 2'd0};
                    r_sel   <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_F1;
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign bus.mem_req      = r_req;
    assign bus.mem_we       = r_we;
    assign bus.mem_data_sel = r_sel;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wdata    = r_wdata;
    assign o_flag_z         = r_z;
    assign o_flag_c         = r_c;
    assign o_halted         = r_halted;
endmodule

// File: tb/tb_nibble_cpu_core.sv
// Directed bench for nibble_cpu_core: small memory model plus cycle-exact checks
// of fetch/execute timing, flags, stores, wait states, pc wrap, halt and reset.
module tb_nibble_cpu_core;
    localparam int DW = 4;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flag_z;
    logic flag_c;
    logic halted;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] mem [1024];

    nibble_cpu_core_if #(.DW(DW), .AW(AW)) bus ();

    nibble_cpu_core #(.DW(DW), .AW(AW), .NREG(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .bus      (bus),
        .o_flag_z (flag_z),
        .o_flag_c (flag_c),
        .o_halted (halted)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Memory commits a store on a completed, non-reset data write.
    always @(posedge clk) begin
        if (!rst && bus.mem_req && bus.mem_ready && bus.mem_we && bus.mem_data_sel) begin
            wr_cnt             <= wr_cnt + 1;
            wr_addr            <= bus.mem_addr;
            wr_data            <= bus.mem_wdata;
            mem[bus.mem_addr]  <= bus.mem_wdata;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
    endtask

    task automatic put(input int idx, input int op, input int rd, input int opr);
        mem[4*idx]     = op[3:0];
        mem[4*idx + 1] = rd[3:0];
        mem[4*idx + 2] = opr[3:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        bus.mem_ready = 1'b1;

        // Program A: ALU, store/load, jumps, halt; ready tied high.
        clear_mem();
        put(0, 1, 1, 5);     // LDI r1,5
        put(1, 4, 1, 12);    // ADD r1,0xC -> 1, C=1
        put(2, 3, 1, 7);     // ST r1,7
        put(3, 2, 2, 7);     // LD r2,7
        put(4, 7, 0, 0);     // XOR r0,0 -> Z=1
        put(5, 9, 0, 10);    // JZ 0xA
        put(10, 4, 3, 0);    // ADD r3,0 -> C=0, Z=1
        put(11, 10, 0, 0);   // JC 0 (not taken)
        put(12, 3, 2, 11);   // ST r2,0xB
        put(13, 11, 0, 0);   // HALT
        do_reset();
        check("rst_req", int'(bus.mem_req), 1);
        check("rst_addr", int'(bus.mem_addr), 0);
        check("rst_we", int'(bus.mem_we), 0);
        check("rst_sel", int'(bus.mem_data_sel), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_z", int'(flag_z), 0);
        check("rst_c", int'(flag_c), 0);
        step(5);
        check("add_pending_c", int'(flag_c), 0);
        step(1);
        check("add_c", int'(flag_c), 1);
        check("add_z", int'(flag_z), 0);
        check("add_next_addr", int'(bus.mem_addr), 8);
        step(3);
        check("st_addr", int'(bus.mem_addr), 7);
        check("st_sel", int'(bus.mem_data_sel), 1);
        check("st_we", int'(bus.mem_we), 1);
        check("st_wdata", int'(bus.mem_wdata), 1);
        step(1);
        check("st_cnt", wr_cnt, 1);
        check("st_waddr", int'(wr_addr), 7);
        check("st_wdata_mem", int'(wr_data), 1);
        check("st_next_addr", int'(bus.mem_addr), 12);
        check("st_sel_back", int'(bus.mem_data_sel), 0);
        step(3);
        check("ld_addr", int'(bus.mem_addr), 7);
        check("ld_sel", int'(bus.mem_data_sel), 1);
        check("ld_we", int'(bus.mem_we), 0);
        step(1);
        check("ld_next_addr", int'(bus.mem_addr), 16);
        step(3);
        check("xor_z", int'(flag_z), 1);
        check("xor_c_kept", int'(flag_c), 1);
        step(3);
        check("jz_target", int'(bus.mem_addr), 'h28);
        step(3);
        check("add0_z", int'(flag_z), 1);
        check("add0_c", int'(flag_c), 0);
        step(3);
        check("jc_fallthru", int'(bus.mem_addr), 'h30);
        step(4);
        check("st2_cnt", wr_cnt, 2);
        check("st2_waddr", int'(wr_addr), 11);
        check("st2_r2", int'(wr_data), 1);
        step(3);
        check("halt_req", int'(bus.mem_req), 0);
        check("halt_flag", int'(halted), 1);
        step(4);
        check("halt_hold", int'(halted), 1);
        check("halt_req_hold", int'(bus.mem_req), 0);

        // Wait states: ready low for three cycles during F2 of ADD.
        clear_mem();
        put(0, 1, 1, 5);
        put(1, 4, 1, 12);
        put(2, 3, 1, 7);
        put(3, 11, 0, 0);
        do_reset();
        step(4);
        check("ws_f2_addr", int'(bus.mem_addr), 5);
        bus.mem_ready = 1'b0;
        step(1);
        check("ws_hold1", int'(bus.mem_addr), 5);
        step(1);
        check("ws_hold2", int'(bus.mem_addr), 5);
        step(1);
        check("ws_hold3", int'(bus.mem_addr), 5);
        check("ws_c_hold", int'(flag_c), 0);
        bus.mem_ready = 1'b1;
        step(1);
        check("ws_f3_addr", int'(bus.mem_addr), 6);
        check("ws_c_late", int'(flag_c), 0);
        step(1);
        check("ws_c", int'(flag_c), 1);
        check("ws_z", int'(flag_z), 0);
        check("ws_next_addr", int'(bus.mem_addr), 8);
        step(4);
        check("ws_st_cnt", wr_cnt, 3);
        check("ws_st_data", int'(wr_data), 1);

        // pc wrap from 0xFF to 0, then HALT placed at instruction 0.
        clear_mem();
        do_reset();
        step(765);
        check("wrap_last_addr", int'(bus.mem_addr), 'h3FC);
        mem[0] = 4'd11;
        step(3);
        check("wrap_addr", int'(bus.mem_addr), 0);
        check("wrap_req", int'(bus.mem_req), 1);
        step(3);
        check("wrap_halted", int'(halted), 1);

        // Reset while a store sits in its memory phase.
        clear_mem();
        put(0, 3, 0, 5);
        do_reset();
        check("rst_clears_halt", int'(halted), 0);
        check("rst_req_back", int'(bus.mem_req), 1);
        step(3);
        check("mr_sel", int'(bus.mem_data_sel), 1);
        check("mr_we", int'(bus.mem_we), 1);
        check("mr_addr", int'(bus.mem_addr), 5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mr_no_write", wr_cnt, 3);
        check("mr_addr0", int'(bus.mem_addr), 0);
        check("mr_sel0", int'(bus.mem_data_sel), 0);
        check("mr_we0", int'(bus.mem_we), 0);
        step(4);
        check("mr_redo_write", wr_cnt, 4);
        check("mr_redo_addr", int'(wr_addr), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
